booth_seq_ctrl: RTL

//  Upstream sequencer for the 8x8 serial Booth multiplier. Accepts operand pairs on a

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_seq_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and sizing for the serial Booth multiplier sequencer.
package booth_pkg;

  localparam int BOOTH_W = 8;
  localparam int LATENCY = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_WAIT = ST_WAIT,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: feeds operand pairs to the serial Booth multiplier and returns its product, with a WAIT watchdog.
// Defining BOOTH_SEQ_ACC_EN adds a running accumulator of good products (res_acc, cleared by acc_clr).
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int W       = BOOTH_W,
  parameter int CYC_MAX = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [W-1:0]   op_mc,
  input  logic [W-1:0]   op_mp,
  output logic           mul_start,
  output logic [W-1:0]   mul_mc,
  output logic [W-1:0]   mul_mp,
  input  logic           mul_busy,
  input  logic [2*W-1:0] mul_prod,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_prod,
  output logic           res_err
`ifdef BOOTH_SEQ_ACC_EN
  ,
  input  logic           acc_clr,
  output logic [2*W+7:0] res_acc
`endif
);

  localparam logic [3:0] WDOG_LAST = 4'(CYC_MAX - 1);

  state_e           r_state;
  logic             r_op_ready;
  logic             r_start;
  logic [W-1:0]     r_mc;
  logic [W-1:0]     r_mp;
  logic [2*W-1:0]   r_prod;
  logic             r_err;
  logic             r_valid;
  logic [3:0]       r_wdog;

  // Sequencer FSM; busy is only trusted from the first WAIT cycle on, and the first !busy is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_ready <= 1'b1;
      r_start    <= 1'b0;
      r_mc       <= {W{1'b0}};
      r_mp       <= {W{1'b0}};
      r_prod     <= {(2*W){1'b0}};
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
      r_wdog     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_mc       <= op_mc;
            r_mp       <= op_mp;
            r_op_ready <= 1'b0;
            r_start    <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_op_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          r_start <= 1'b0;
          r_wdog  <= 4'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!mul_busy) begin
            r_prod  <= mul_prod;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (r_wdog == WDOG_LAST) begin
            r_prod  <= {(2*W){1'b0}};
            r_err   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 4'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_valid    <= 1'b0;
            r_op_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b1;
          r_start    <= 1'b0;
          r_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready  = r_op_ready;
  assign mul_start = r_start;
  assign mul_mc    = r_mc;
  assign mul_mp    = r_mp;
  assign res_valid = r_valid;
  assign res_prod  = r_prod;
  assign res_err   = r_err;

`ifdef BOOTH_SEQ_ACC_EN
  logic             w_xfer;
  logic [2*W+7:0]   r_acc;

  assign w_xfer = (r_state == S_DONE) && res_ready && !r_err;

  // Running sum of good products; a same-cycle clear drops the product being returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= {(2*W+8){1'b0}};
    end else if (acc_clr) begin
      r_acc <= {(2*W+8){1'b0}};
    end else if (w_xfer) begin
      r_acc <= r_acc + {{8{r_prod[2*W-1]}}, r_prod};
    end else begin
      r_acc <= r_acc;
    end
  end

  assign res_acc = r_acc;
`endif

endmodule
